// File: rtl/tcdm_port_arbiter.sv
// tcdm_port_arbiter
//   Shares one TCDM slave port among N_REQ requesters. Round-robin arbitration
//   with the selection held (locked) while the memory stalls. An in-order routing
//   FIFO remembers which requester issued each granted transaction so every
//   r_valid from memory is steered back to its owner.
//
// Ports
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   req_i/add_i/wen_i/be_i/data_i   per-requester request fields (wen=1 read)
//   gnt_o, r_valid_o         per-requester grant / response valid
//   r_data_o                 response data broadcast to every requester
//   req_o/add_o/wen_o/be_o/data_o   muxed request to the memory port
//   gnt_i, r_data_i, r_valid_i      memory grant and in-order response
//   busy_o                   transactions outstanding or a request pending
module tcdm_port_arbiter #(
  parameter int N_REQ   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [N_REQ-1:0][AW-1:0]       add_i,
  input  logic [N_REQ-1:0]               wen_i,
  input  logic [N_REQ-1:0][DW/8-1:0]     be_i,
  input  logic [N_REQ-1:0][DW-1:0]       data_i,
  output logic [N_REQ-1:0]               gnt_o,
  output logic [N_REQ-1:0][DW-1:0]       r_data_o,
  output logic [N_REQ-1:0]               r_valid_o,
  output logic                           req_o,
  output logic [AW-1:0]                  add_o,
  output logic                           wen_o,
  output logic [DW/8-1:0]                be_o,
  output logic [DW-1:0]                  data_o,
  input  logic                           gnt_i,
  input  logic [DW-1:0]                  r_data_i,
  input  logic                           r_valid_i,
  output logic                           busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic                       lock_q, lock_d;
  logic [IW-1:0]              sel_q, sel_d;
  logic [MAX_OUT-1:0][IW-1:0] mem_q, mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic [IW-1:0] rr_sel, sel, head;
  logic          found, lock_drop, fifo_full, fifo_empty, full_blk, hs, pop;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    rr_sel = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[(int'(rr_ptr_q) + k) % N_REQ]) begin
        rr_sel = IW'((int'(rr_ptr_q) + k) % N_REQ);
        found  = 1'b1;
      end
    end
  end

  assign sel        = lock_q ? sel_q : rr_sel;
  // Locked requester withdrew: hold off this cycle, re-arbitrate next cycle.
  assign lock_drop  = lock_q & ~req_i[sel_q];
  assign fifo_full  = (cnt_q == CW'(MAX_OUT));
  assign fifo_empty = (cnt_q == '0);
  // A same-cycle pop frees the slot the new push needs.
  assign full_blk   = fifo_full & ~r_valid_i;
  assign req_o      = (|req_i) & ~full_blk & ~lock_drop & ~rst_i;
  assign hs         = req_o & gnt_i;
  assign pop        = r_valid_i & ~fifo_empty & ~rst_i;
  assign head       = mem_q[rd_ptr_q];
  assign busy_o     = ~fifo_empty | req_o;

  assign add_o  = add_i[sel];
  assign wen_o  = wen_i[sel];
  assign be_o   = be_i[sel];
  assign data_o = data_i[sel];

  for (genvar i = 0; i < N_REQ; i++) begin : g_port
    assign gnt_o[i]     = hs  & (sel  == IW'(i));
    assign r_valid_o[i] = pop & (head == IW'(i));
    assign r_data_o[i]  = r_data_i;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    sel_d    = sel_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (hs) begin
      rr_ptr_d       = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
      lock_d         = 1'b0;
      mem_d[wr_ptr_q] = sel;
      wr_ptr_d       = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end else if (req_o) begin
      // Stall: pin the selection so the memory sees a stable request.
      lock_d = 1'b1;
      sel_d  = sel;
    end else if (lock_drop) begin
      lock_d = 1'b0;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(hs) - CW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i) !lock_drop)
    else $warning("tcdm_port_arbiter: locked requester dropped req before grant");
  a_rvalid_owner: assert property (@(posedge clk_i) disable iff (rst_i) !(r_valid_i && fifo_empty))
    else $warning("tcdm_port_arbiter: r_valid_i with no outstanding transaction, dropped");
`endif

endmodule
